// File: rtl/bp_resolve_ctrl_pkg.sv
// Shared types and defaults for the branch-predictor resolve controller.
// Holds table geometry, counter encodings, FSM states and the in-flight record.
package bp_pkg;

   localparam int BP_ENTRIES = 128;
   localparam int BP_IDX_W   = 7;
   localparam int BP_PC_W    = 32;
   localparam int BP_Q_DEPTH = 4;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   typedef enum logic {CLEAR, RUN} bp_state_e;

   typedef struct packed {
      logic [BP_PC_W-1:0] pc;
      logic               hit;
      logic               pred_taken;
      logic [BP_PC_W-1:0] pred_target;
      logic [1:0]         ctr;
   } bp_rec_t;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == CTR_ST) ? CTR_ST : c + 2'd1;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/bp_resolve_ctrl_if.sv
// Fetch/resolve handshake, table write port and status bundle of bp_resolve_ctrl.
interface bp_resolve_ctrl_if #(
   parameter int PC_W  = bp_pkg::BP_PC_W,
   parameter int IDX_W = bp_pkg::BP_IDX_W
);
   logic             f_valid;
   logic             f_ready;
   logic [PC_W-1:0]  f_pc;
   logic             f_hit;
   logic             f_pred_taken;
   logic [PC_W-1:0]  f_pred_target;
   logic [1:0]       f_ctr;
   logic             r_valid;
   logic             r_is_branch;
   logic             r_taken;
   logic [PC_W-1:0]  r_target;
   logic             clear_req;
   logic             busy;
   logic             flush;
   logic [PC_W-1:0]  redirect_pc;
   logic             bw_en;
   logic [IDX_W-1:0] bw_idx;
   logic [PC_W-1:0]  bw_tag;
   logic [PC_W-1:0]  bw_target;
   logic [1:0]       bw_ctr;
   logic             bw_valid;
   logic [31:0]      stat_resolved;
   logic [31:0]      stat_mispredict;

   modport slave (
      input  f_valid, f_pc, f_hit, f_pred_taken, f_pred_target, f_ctr,
      input  r_valid, r_is_branch, r_taken, r_target, clear_req,
      output f_ready, busy, flush, redirect_pc,
      output bw_en, bw_idx, bw_tag, bw_target, bw_ctr, bw_valid,
      output stat_resolved, stat_mispredict
   );

   modport master (
      output f_valid, f_pc, f_hit, f_pred_taken, f_pred_target, f_ctr,
      output r_valid, r_is_branch, r_taken, r_target, clear_req,
      input  f_ready, busy, flush, redirect_pc,
      input  bw_en, bw_idx, bw_tag, bw_target, bw_ctr, bw_valid,
      input  stat_resolved, stat_mispredict
   );
endinterface

// File: rtl/bp_inflight_fifo.sv
// In-order queue of in-flight prediction records; clr empties it and wins over push/pop.
module bp_inflight_fifo import bp_pkg::*; #(
   parameter int Q_DEPTH = BP_Q_DEPTH
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  bp_rec_t wdata,
   input  logic    pop,
   input  logic    clr,
   output bp_rec_t rdata,
   output logic    full,
   output logic    empty
);
   localparam int AW = $clog2(Q_DEPTH);
   localparam int CW = AW + 1;

   bp_rec_t         mem_q [Q_DEPTH];
   bp_rec_t         mem_d [Q_DEPTH];
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (clr) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
         end
         if (pop) rd_d = rd_q + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign rdata = mem_q[rd_q];
   assign full  = (cnt_q == CW'(Q_DEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/bp_resolve_ctrl.sv
// Branch predictor resolve controller: in-flight tracking, mispredict flush, BTB/BHT write port.
// Optional statistics counters are built when BP_STATS_EN is defined.
//
// state | meaning
// CLEAR | sweep writes every set invalid; fetch stalled, resolves ignored
// RUN   | accept predictions, resolve oldest, update table on resolution
module bp_resolve_ctrl import bp_pkg::*; #(
   parameter int ENTRIES = BP_ENTRIES,
   parameter int IDX_W   = BP_IDX_W,
   parameter int Q_DEPTH = BP_Q_DEPTH,
   parameter int PC_W    = BP_PC_W
) (
   input logic              clk,
   input logic              rst_n,
   bp_resolve_ctrl_if.slave bus
);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] SWEEP_END = CNT_W'(ENTRIES);

   bp_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flush_q, flush_d;
   logic [PC_W-1:0]  redirect_q, redirect_d;
   logic             bw_en_q, bw_en_d;
   logic [IDX_W-1:0] bw_idx_q, bw_idx_d;
   logic [PC_W-1:0]  bw_tag_q, bw_tag_d;
   logic [PC_W-1:0]  bw_target_q, bw_target_d;
   logic [1:0]       bw_ctr_q, bw_ctr_d;
   logic             bw_valid_q, bw_valid_d;

   logic    f_ready, q_push, q_pop, q_clr, q_full, q_empty, mispredict;
   bp_rec_t q_wdata, head;

   // Ready depends only on flops so the fetch side never sees a path from r_valid.
   assign f_ready = (state_q == RUN) && !q_full && !flush_q;
   assign q_push  = bus.f_valid && f_ready;
   assign q_wdata = '{pc: bus.f_pc, hit: bus.f_hit, pred_taken: bus.f_pred_taken,
                      pred_target: bus.f_pred_target, ctr: bus.f_ctr};

   bp_inflight_fifo #(.Q_DEPTH(Q_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (q_push),
      .wdata (q_wdata),
      .pop   (q_pop),
      .clr   (q_clr),
      .rdata (head),
      .full  (q_full),
      .empty (q_empty)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      flush_d     = 1'b0;
      redirect_d  = '0;
      bw_en_d     = 1'b0;
      bw_idx_d    = '0;
      bw_tag_d    = '0;
      bw_target_d = '0;
      bw_ctr_d    = CTR_SNT;
      bw_valid_d  = 1'b0;
      q_pop       = 1'b0;
      q_clr       = 1'b0;
      mispredict  = 1'b0;
      unique case (state_q)
         CLEAR: begin
            q_clr = 1'b1;
            if (cnt_q == SWEEP_END) begin
               state_d = RUN;
            end else begin
               bw_en_d  = 1'b1;
               bw_idx_d = cnt_q[IDX_W-1:0];
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (bus.clear_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
               q_clr   = 1'b1;
            end else if (bus.r_valid && !q_empty) begin
               q_pop = 1'b1;
               if (bus.r_is_branch)
                  mispredict = (bus.r_taken != head.pred_taken) ||
                               (bus.r_taken && head.pred_taken && bus.r_target != head.pred_target);
               else
                  mispredict = head.hit && head.pred_taken;
               flush_d = mispredict;
               q_clr   = mispredict;
               if (mispredict)
                  redirect_d = (bus.r_is_branch && bus.r_taken) ? bus.r_target : head.pc + PC_W'(4);
               bw_idx_d = head.pc[IDX_W+1:2];
               bw_tag_d = head.pc;
               if (bus.r_is_branch && head.hit) begin
                  bw_en_d     = 1'b1;
                  bw_valid_d  = 1'b1;
                  bw_ctr_d    = bus.r_taken ? ctr_inc(head.ctr) : ctr_dec(head.ctr);
                  bw_target_d = bus.r_taken ? bus.r_target : head.pred_target;
               end else if (bus.r_is_branch && bus.r_taken) begin
                  bw_en_d     = 1'b1;
                  bw_valid_d  = 1'b1;
                  bw_ctr_d    = CTR_WT;
                  bw_target_d = bus.r_target;
               end else if (!bus.r_is_branch && head.hit) begin
                  bw_en_d    = 1'b1;
                  bw_valid_d = 1'b0;
                  bw_ctr_d   = CTR_SNT;
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         cnt_q       <= '0;
         flush_q     <= 1'b0;
         redirect_q  <= '0;
         bw_en_q     <= 1'b0;
         bw_idx_q    <= '0;
         bw_tag_q    <= '0;
         bw_target_q <= '0;
         bw_ctr_q    <= CTR_SNT;
         bw_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flush_q     <= flush_d;
         redirect_q  <= redirect_d;
         bw_en_q     <= bw_en_d;
         bw_idx_q    <= bw_idx_d;
         bw_tag_q    <= bw_tag_d;
         bw_target_q <= bw_target_d;
         bw_ctr_q    <= bw_ctr_d;
         bw_valid_q  <= bw_valid_d;
      end
   end

   assign bus.f_ready     = f_ready;
   assign bus.busy        = (state_q == CLEAR);
   assign bus.flush       = flush_q;
   assign bus.redirect_pc = redirect_q;
   assign bus.bw_en       = bw_en_q;
   assign bus.bw_idx      = bw_idx_q;
   assign bus.bw_tag      = bw_tag_q;
   assign bus.bw_target   = bw_target_q;
   assign bus.bw_ctr      = bw_ctr_q;
   assign bus.bw_valid    = bw_valid_q;

`ifdef BP_STATS_EN
   logic [31:0] stat_res_q, stat_res_d, stat_mis_q, stat_mis_d;

   // Cleared by rst_n only; a clear sweep leaves the history intact.
   always_comb begin
      stat_res_d = stat_res_q + 32'(q_pop);
      stat_mis_d = stat_mis_q + 32'(flush_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_res_q <= '0;
         stat_mis_q <= '0;
      end else begin
         stat_res_q <= stat_res_d;
         stat_mis_q <= stat_mis_d;
      end
   end

   assign bus.stat_resolved   = stat_res_q;
   assign bus.stat_mispredict = stat_mis_q;
`else
   assign bus.stat_resolved   = '0;
   assign bus.stat_mispredict = '0;
`endif

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Directed bench for bp_resolve_ctrl with a queue-based reference model checked every cycle.
module tb_bp_resolve_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bp_resolve_ctrl_if bus ();
   bp_resolve_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      bit          hit;
      bit          pt;
      logic [31:0] ptgt;
      int          ctr;
   } mrec_t;

   mrec_t       mq[$];
   mrec_t       m_rec;
   bit          m_hs;
   bit          m_sweep = 1'b1;
   int          m_idx = 0;
   bit          m_ready = 1'b0;
   bit          e_flush = 1'b0, e_en = 1'b0, e_valid = 1'b0, e_chk_tgt = 1'b0;
   logic [31:0] e_redir = '0, e_tag = '0, e_tgt = '0;
   int          e_idx = 0, e_ctr = 0;
   logic [31:0] m_res = '0, m_mis = '0;

   task automatic model_resolve(input mrec_t r, input bit br, input bit tk, input logic [31:0] tgt);
      bit mis;
      if (br) mis = (tk != r.pt) || (tk && r.pt && tgt != r.ptgt);
      else    mis = r.hit && r.pt;
      e_flush = mis;
      if (mis) e_redir = (br && tk) ? tgt : r.pc + 32'd4;
      e_idx = int'((r.pc / 4) % 128);
      e_tag = r.pc;
      if (br && r.hit) begin
         e_en = 1; e_valid = 1;
         e_ctr = tk ? ((r.ctr == 3) ? 3 : r.ctr + 1) : ((r.ctr == 0) ? 0 : r.ctr - 1);
         e_tgt = tk ? tgt : r.ptgt;
      end else if (br && tk) begin
         e_en = 1; e_valid = 1; e_ctr = 2; e_tgt = tgt;
      end else if (!br && r.hit) begin
         e_en = 1; e_valid = 0; e_ctr = 0; e_chk_tgt = 0;
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_sweep = 1; m_idx = 0; m_ready = 0;
         e_flush = 0; e_en = 0; m_res = '0; m_mis = '0;
      end else begin
         m_hs = bus.f_valid && m_ready;
         e_flush = 0; e_en = 0; e_valid = 0; e_redir = '0; e_tag = '0; e_tgt = '0;
         e_idx = 0; e_ctr = 0; e_chk_tgt = 1;
         if (m_sweep) begin
            if (m_idx < 128) begin
               e_en = 1; e_idx = m_idx; m_idx++;
            end else begin
               m_sweep = 0;
            end
         end else if (bus.clear_req) begin
            mq.delete();
            m_sweep = 1; m_idx = 0;
         end else begin
            if (bus.r_valid && mq.size() > 0) begin
               m_rec = mq.pop_front();
               m_res++;
               model_resolve(m_rec, bus.r_is_branch, bus.r_taken, bus.r_target);
            end
            if (e_flush) mq.delete();
            else if (m_hs)
               mq.push_back('{bus.f_pc, bus.f_hit, bus.f_pred_taken, bus.f_pred_target, int'(bus.f_ctr)});
         end
         if (e_flush) m_mis++;
         m_ready = !m_sweep && mq.size() < 4 && !e_flush;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_busy", bus.busy, m_sweep);
         chk("m_f_ready", bus.f_ready, m_ready);
         chk("m_flush", bus.flush, e_flush);
         chk("m_bw_en", bus.bw_en, e_en);
         if (e_flush) chk("m_redirect", bus.redirect_pc, e_redir);
         if (e_en) begin
            chk("m_bw_idx", bus.bw_idx, e_idx);
            chk("m_bw_valid", bus.bw_valid, e_valid);
            chk("m_bw_ctr", bus.bw_ctr, e_ctr);
            chk("m_bw_tag", bus.bw_tag, e_tag);
            if (e_chk_tgt) chk("m_bw_target", bus.bw_target, e_tgt);
         end
`ifdef BP_STATS_EN
         chk("m_stat_res", bus.stat_resolved, m_res);
         chk("m_stat_mis", bus.stat_mispredict, m_mis);
`else
         chk("m_stat_res", bus.stat_resolved, 32'd0);
         chk("m_stat_mis", bus.stat_mispredict, 32'd0);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] pc, input bit hit, input bit pt,
                       input logic [31:0] ptgt, input logic [1:0] ctr);
      chk("push_ready", bus.f_ready, 1);
      bus.f_valid = 1; bus.f_pc = pc; bus.f_hit = hit; bus.f_pred_taken = pt;
      bus.f_pred_target = ptgt; bus.f_ctr = ctr;
      @(negedge clk);
      bus.f_valid = 0;
   endtask

   task automatic resolve(input bit br, input bit tk, input logic [31:0] tgt);
      bus.r_valid = 1; bus.r_is_branch = br; bus.r_taken = tk; bus.r_target = tgt;
      @(negedge clk);
      bus.r_valid = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.f_valid = 0; bus.f_pc = '0; bus.f_hit = 0; bus.f_pred_taken = 0;
      bus.f_pred_target = '0; bus.f_ctr = '0; bus.r_valid = 0; bus.r_is_branch = 0;
      bus.r_taken = 0; bus.r_target = '0; bus.clear_req = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 1);
      chk("rst_bw_en", bus.bw_en, 0);
      chk("rst_f_ready", bus.f_ready, 0);
      chk("rst_flush", bus.flush, 0);
      chk("rst_redirect", bus.redirect_pc, 0);
      rst_n = 1;

      for (int k = 1; k <= 128; k++) begin
         @(negedge clk);
         chk("sweep_en", bus.bw_en, 1);
         chk("sweep_idx", bus.bw_idx, k - 1);
         chk("sweep_valid", bus.bw_valid, 0);
      end
      @(negedge clk);
      chk("post_sweep_busy", bus.busy, 0);
      chk("post_sweep_ready", bus.f_ready, 1);
      chk("post_sweep_en", bus.bw_en, 0);

      // miss, taken branch -> allocate weak-taken
      push(32'h10, 0, 0, 32'h0, 2'b00);
      resolve(1, 1, 32'h24);
      chk("alloc_flush", bus.flush, 1);
      chk("alloc_redirect", bus.redirect_pc, 32'h24);
      chk("alloc_idx", bus.bw_idx, 4);
      chk("alloc_tag", bus.bw_tag, 32'h10);
      chk("alloc_target", bus.bw_target, 32'h24);
      chk("alloc_ctr", bus.bw_ctr, 2);
      chk("alloc_valid", bus.bw_valid, 1);
      chk("alloc_ready", bus.f_ready, 0);
      idle();

      // saturating increment, correct prediction
      push(32'h20, 1, 1, 32'h24, 2'b11);
      resolve(1, 1, 32'h24);
      chk("sat_flush", bus.flush, 0);
      chk("sat_ctr", bus.bw_ctr, 3);
      chk("sat_idx", bus.bw_idx, 8);
      idle();

      // direction mispredict
      push(32'h10, 1, 1, 32'h24, 2'b10);
      resolve(1, 0, 32'h0);
      chk("dir_flush", bus.flush, 1);
      chk("dir_redirect", bus.redirect_pc, 32'h14);
      chk("dir_ctr", bus.bw_ctr, 1);
      chk("dir_target", bus.bw_target, 32'h24);
      idle();

      // target mispredict
      push(32'h40, 1, 1, 32'h80, 2'b01);
      resolve(1, 1, 32'h90);
      chk("tgt_redirect", bus.redirect_pc, 32'h90);
      chk("tgt_ctr", bus.bw_ctr, 2);
      idle();

      // non-branch predicted taken -> invalidate + flush
      push(32'h50, 1, 1, 32'h60, 2'b11);
      resolve(0, 0, 32'h0);
      chk("nb_flush", bus.flush, 1);
      chk("nb_redirect", bus.redirect_pc, 32'h54);
      chk("nb_valid", bus.bw_valid, 0);
      chk("nb_idx", bus.bw_idx, 20);
      idle();

      // non-branch hit, not taken -> invalidate, no flush
      push(32'h58, 1, 0, 32'h0, 2'b01);
      resolve(0, 0, 32'h0);
      chk("nbnt_flush", bus.flush, 0);
      chk("nbnt_en", bus.bw_en, 1);

      // branch miss not taken -> nothing
      push(32'h60, 0, 0, 32'h0, 2'b00);
      resolve(1, 0, 32'h0);
      chk("bmnt_en", bus.bw_en, 0);
      chk("bmnt_flush", bus.flush, 0);

      // push and pop in the same cycle
      push(32'h100, 0, 0, 32'h0, 2'b00);
      bus.f_valid = 1; bus.f_pc = 32'h104; bus.f_hit = 0; bus.f_pred_taken = 0;
      bus.r_valid = 1; bus.r_is_branch = 1; bus.r_taken = 0;
      @(negedge clk);
      bus.f_valid = 0; bus.r_valid = 0;
      chk("pp_flush", bus.flush, 0);
      resolve(1, 1, 32'h300);
      chk("pp_redirect", bus.redirect_pc, 32'h300);
      chk("pp_idx", bus.bw_idx, 32'h41);
      idle();

      // fill queue, mispredict clears it
      for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 0, 0, 32'h0, 2'b00);
      chk("full_ready", bus.f_ready, 0);
      resolve(1, 1, 32'h400);
      chk("full_flush", bus.flush, 1);
      chk("full_redirect", bus.redirect_pc, 32'h400);
      chk("full_ready_flush", bus.f_ready, 0);
      idle();
      chk("full_ready_after", bus.f_ready, 1);
      resolve(1, 1, 32'h500);
      chk("empty_flush", bus.flush, 0);
      chk("empty_en", bus.bw_en, 0);

      // pc+4 wraps modulo 2^32
      push(32'hFFFF_FFFC, 1, 1, 32'h0, 2'b11);
      resolve(0, 0, 32'h0);
      chk("wrap_redirect", bus.redirect_pc, 32'h0);
      chk("wrap_idx", bus.bw_idx, 127);
      idle();

      // clear request with two records queued
      push(32'h600, 1, 1, 32'h700, 2'b10);
      push(32'h604, 1, 1, 32'h700, 2'b10);
      bus.clear_req = 1;
      @(negedge clk);
      bus.clear_req = 0;
      chk("clr_busy", bus.busy, 1);
      for (int i = 1; i <= 128; i++) begin
         bus.r_valid = (i == 50); bus.r_is_branch = 1; bus.r_taken = 1; bus.r_target = 32'h700;
         @(negedge clk);
         chk("clr_busy", bus.busy, 1);
      end
      bus.r_valid = 0;
      @(negedge clk);
      chk("clr_done_busy", bus.busy, 0);
      chk("clr_done_ready", bus.f_ready, 1);
      resolve(1, 1, 32'h800);
      chk("clr_empty_flush", bus.flush, 0);
      chk("clr_empty_en", bus.bw_en, 0);
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/bp_resolve_ctrl.md
Name: bp_resolve_ctrl

Overview:
- Sequences the dynamic branch predictor (BTB + 2-bit BHT, ENTRIES sets) between the fetch and resolve stages of the MIPS pipeline.
- Tracks in-flight predictions in a small in-order queue and compares each one against the resolved outcome.
- Generates the flush/redirect pulse and owns the single BTB/BHT write port.
- After reset or on request, runs a clear sweep over the table.

Parameters:
- ENTRIES, 128, number of BTB/BHT sets.
- IDX_W, 7, log2(ENTRIES); set index = pc[IDX_W+1:2].
- Q_DEPTH, 4, in-flight prediction records; power of two.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- f_valid  in  1  fetch presents a looked-up PC.
- f_ready  out  1  record accepted when f_valid && f_ready.
- f_pc  in  PC_W  fetched PC.
- f_hit  in  1  BTB tag match with valid entry.
- f_pred_taken  in  1  prediction used by fetch.
- f_pred_target  in  PC_W  predicted target.
- f_ctr  in  2  BHT counter read at lookup.
- r_valid  in  1  oldest in-flight instruction resolved.
- r_is_branch  in  1  resolved instruction is a conditional branch.
- r_taken  in  1  actual direction.
- r_target  in  PC_W  actual taken target.
- clear_req  in  1  single-cycle request to invalidate the table.
- busy  out  1  clear sweep in progress.
- flush  out  1  one-cycle mispredict pulse.
- redirect_pc  out  PC_W  correct fetch PC, valid with flush.
- bw_en  out  1  table write strobe.
- bw_idx  out  IDX_W  write set.
- bw_tag  out  PC_W  full branch PC.
- bw_target  out  PC_W  target written.
- bw_ctr  out  2  counter written.
- bw_valid  out  1  entry valid bit written.

Behaviour:
- Reset values (async on rst_n low):
  - FSM = CLEAR, sweep counter = 0, queue empty.
  - flush, bw_en, f_ready = 0; busy = 1; all data outputs = 0.
- FSM states:
  - CLEAR: each cycle drives bw_en=1, bw_idx=counter, bw_valid=0, bw_ctr=00, bw_tag=0, bw_target=0.
  - CLEAR: after bw_idx=ENTRIES-1 the FSM moves to RUN the next cycle and busy drops.
  - The sweep takes exactly ENTRIES cycles. f_ready=0 throughout; r_valid is ignored.
  - RUN: clear_req empties the queue and enters CLEAR with counter=0.
  - RUN: a r_valid in the same cycle as clear_req is dropped.
- Queue (in-order):
  - f_ready = (state==RUN) && !full && !flush. It is registered-state only, with no combinational path from r_valid.
  - A record {pc, hit, pred_taken, pred_target, ctr} is pushed on a handshake.
  - Each r_valid pops the head. r_valid with an empty queue is ignored: no write, no flush.
  - Push and pop in the same cycle are both honoured.
- Resolution (all outputs registered, 1-cycle latency after r_valid):
  - Mispredict when:
    - r_is_branch && (r_taken != pred_taken), or
    - r_is_branch && r_taken && pred_taken && r_target != pred_target, or
    - !r_is_branch && hit && pred_taken.
  - On mispredict:
    - flush=1 for one cycle.
    - redirect_pc = (r_is_branch && r_taken) ? r_target : pc+4, modulo 2^PC_W.
    - The entire queue is cleared in that cycle, since younger records are wrong-path. A push offered in that cycle is not accepted.
- Table write (same cycle as flush):
  - Branch, hit: bw_ctr = saturating ctr+1 if taken, ctr-1 if not, saturating at 11 and 00. Also bw_valid=1, bw_target=r_taken ? r_target : pred_target.
  - Branch, miss, taken: allocate with bw_ctr=10 (weak taken), bw_valid=1, bw_tag=pc, bw_target=r_target.
  - Branch, miss, not taken: no write.
  - Non-branch, hit: invalidate with bw_valid=0, bw_ctr=00.
  - Non-branch, miss: no write.
- Port ownership: CLEAR owns the write port exclusively and RUN writes only on resolution, so the port never has a conflict.
- Reset mid-sweep or mid-run aborts everything and restarts the sweep from index 0.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_resolved[31:0] and stat_mispredict[31:0].
  - They count accepted resolutions (r_valid with a non-empty queue) and flush pulses, wrapping at 2^32.
  - Both are cleared by rst_n only, not by clear_req.
- Undefined: the ports still exist and are tied to 0, and no counter logic is built.

Decomposition:
- Package bp_pkg holds:
  - ENTRIES, IDX_W, PC_W defaults.
  - Counter encodings CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
  - FSM state enum {CLEAR, RUN}.
  - Packed in-flight record typedef.
  - Saturating-counter increment/decrement functions.
- Sub-module bp_inflight_fifo: parameterised by Q_DEPTH, with push, pop, flush-clear and full/empty.

Test Plan:
- Reset release: bw_en high for 128 consecutive cycles, bw_idx 0→127, bw_valid=0. Then busy=0 and f_ready=1 on cycle 129.
- Miss allocate: push pc=0x10, hit=0, pred_taken=0; resolve branch taken, target 0x24. Next cycle: flush=1, redirect_pc=0x24, bw_idx=4, bw_tag=0x10, bw_target=0x24, bw_ctr=10, bw_valid=1.
- Saturation: hit, ctr=11, pred taken to 0x24; resolve taken to 0x24. Result: flush=0, bw_ctr=11.
- Direction mispredict: hit, ctr=10, pred taken; resolve not taken. Result: flush=1, redirect_pc=0x14, bw_ctr=01.
- Full/flush: 4 pushes with no resolve drive f_ready=0. A mispredicting resolve then clears the queue, and f_ready=1 two cycles later. A following r_valid is ignored (empty).
- clear_req with 2 records queued: queue emptied, 128-cycle sweep, busy=1 throughout. An r_valid during the sweep is ignored. With BP_STATS_EN defined, stat counters are unchanged by the sweep.
